// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a first-word-fall-through transmit FIFO
// Ports:
//   clk_sys, rst_n       system clock, asynchronous active-low reset
//   baud_rate            bit period in clk_sys cycles (values below 2 act as 2)
//   data_width           data bits per frame (clamped to 5..DW_MAX)
//   check_en, check_sel  parity enable, parity sense (0 even, 1 odd)
//   stop_bit             0 one stop bit, 1 two stop bits
//   break_req            hold the line low once the transmitter is idle
//   tx_en, tx_data       FIFO write strobe and word
//   tx_full, tx_level    FIFO full flag and occupancy
//   tx_ovf               one-cycle pulse after a dropped write
//   tx_busy, tx_done     transmitter active, last cycle of a frame
//   uart_tx              registered serial line, idles high
module uart_tx_fifo #(
    parameter int U_DLY   = 1,
    parameter int DW_MAX  = 8,
    parameter int FIFO_AW = 4,
    parameter int BAUD_W  = 16
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic [BAUD_W-1:0]  baud_rate,
    input  logic [3:0]         data_width,
    input  logic               check_en,
    input  logic               check_sel,
    input  logic               stop_bit,
    input  logic               break_req,
    input  logic               tx_en,
    input  logic [DW_MAX-1:0]  tx_data,
    output logic               tx_full,
    output logic [FIFO_AW:0]   tx_level,
    output logic               tx_ovf,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               uart_tx
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [3:0] DW_HI = 4'(DW_MAX);

    // U_DLY is accepted for compatibility with delayed-assignment models;
    // synthesizable registers carry no delay.
    if (U_DLY < 0) begin : g_u_dly
    end

    logic [DW_MAX-1:0]  mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [2:0]         state;
    logic [BAUD_W-1:0]  baud_cnt, f_baud, baud_c;
    logic [3:0]         bit_cnt, f_dw, dw_c;
    logic [DW_MAX-1:0]  shreg, rd_data;
    logic               f_par_en, f_par, f_stop, f_brk;
    logic               par_c, push, pop, bit_end;

    assign rd_data  = mem[rd_ptr];
    assign dw_c     = data_width < 4'd5 ? 4'd5 : (data_width > DW_HI ? DW_HI : data_width);
    assign baud_c   = baud_rate < BAUD_W'(2) ? BAUD_W'(2) : baud_rate;
    assign tx_full  = level == DEPTH;
    assign tx_level = level;
    assign tx_busy  = state != IDLE;
    assign push     = tx_en && !tx_full;
    assign pop      = state == IDLE && !break_req && level != '0;
    assign bit_end  = baud_cnt == f_baud - BAUD_W'(1);
    // f_brk marks the stop period that follows a break, which is not a frame
    assign tx_done  = state == STOP && bit_end && bit_cnt == {3'b0, f_stop} && !f_brk;

    // parity over the clamped number of data bits of the head word
    always_comb begin
        par_c = check_sel;
        for (int i = 0; i < DW_MAX; i++)
            par_c = par_c ^ (rd_data[i] & (4'(i) < dw_c));
    end

    always_ff @(posedge clk_sys)
        if (push) mem[wr_ptr] <= tx_data;

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tx_ovf   <= 1'b0;
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            f_dw     <= 4'd5;
            f_baud   <= BAUD_W'(2);
            f_par_en <= 1'b0;
            f_par    <= 1'b0;
            f_stop   <= 1'b0;
            f_brk    <= 1'b0;
        end else begin
            tx_ovf   <= tx_en && tx_full;
            wr_ptr   <= wr_ptr + {{(FIFO_AW-1){1'b0}}, push};
            rd_ptr   <= rd_ptr + {{(FIFO_AW-1){1'b0}}, pop};
            level    <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            baud_cnt <= (state == IDLE || state == BREAK || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE:
                    if (break_req) begin
                        state   <= BREAK;
                        uart_tx <= 1'b0;
                    end else if (pop) begin
                        state    <= START;
                        uart_tx  <= 1'b0;
                        shreg    <= rd_data;
                        f_dw     <= dw_c;
                        f_par_en <= check_en;
                        f_par    <= par_c;
                        f_stop   <= stop_bit;
                        f_baud   <= baud_c;
                        f_brk    <= 1'b0;
                    end
                START:
                    if (bit_end) begin
                        state   <= DATA;
                        uart_tx <= shreg[0];
                        bit_cnt <= '0;
                    end
                DATA:
                    if (bit_end) begin
                        if (bit_cnt == f_dw - 4'd1) begin
                            state   <= f_par_en ? PARITY : STOP;
                            uart_tx <= f_par_en ? f_par : 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            uart_tx <= shreg[1];
                        end
                    end
                PARITY:
                    if (bit_end) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                    end
                STOP:
                    if (bit_end) begin
                        state   <= bit_cnt == {3'b0, f_stop} ? IDLE : STOP;
                        bit_cnt <= bit_cnt == {3'b0, f_stop} ? 4'd0 : bit_cnt + 1'b1;
                    end
                BREAK:
                    if (!break_req) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                        f_baud  <= baud_c;
                        f_stop  <= 1'b0;
                        f_brk   <= 1'b1;
                        bit_cnt <= '0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench against a queue-based line model
module tb_uart_tx_fifo;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_rate = 16'd4;
    logic [3:0]  data_width = 4'd8;
    logic        check_en = 1'b0, check_sel = 1'b0, stop_bit = 1'b0, break_req = 1'b0;
    logic        tx_en = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_full, tx_ovf, tx_busy, tx_done, uart_tx;
    logic [4:0]  tx_level;

    uart_tx_fifo dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .baud_rate(baud_rate), .data_width(data_width),
        .check_en(check_en), .check_sel(check_sel), .stop_bit(stop_bit), .break_req(break_req),
        .tx_en(tx_en), .tx_data(tx_data), .tx_full(tx_full), .tx_level(tx_level),
        .tx_ovf(tx_ovf), .tx_busy(tx_busy), .tx_done(tx_done), .uart_tx(uart_tx)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_err = 0;
    int exp_done = 0, got_done = 0;
    logic [7:0] mq[$];
    bit lq[$];
    bit dq[$];
    bit brk = 1'b0, ovf_e = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        lq.delete();
        dq.delete();
        brk = 1'b0;
        ovf_e = 1'b0;
    endtask

    function automatic int clamp_baud();
        return baud_rate < 16'd2 ? 2 : int'(baud_rate);
    endfunction

    task automatic build_frame(input logic [7:0] w);
        int b, n;
        logic [7:0] m;
        bit bits[$];
        b = clamp_baud();
        n = data_width < 4'd5 ? 5 : (data_width > 4'd8 ? 8 : int'(data_width));
        m = w & 8'((1 << n) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(w[i]);
        if (check_en) bits.push_back(($countones(m) % 2 == 1) ^ check_sel);
        repeat (stop_bit ? 2 : 1) bits.push_back(1'b1);
        foreach (bits[i])
            for (int j = 0; j < b; j++) begin
                lq.push_back(bits[i]);
                dq.push_back(1'b0);
            end
        dq[dq.size()-1] = 1'b1;
        exp_done++;
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // by one clock using the inputs currently driven.
    task automatic cyc();
        logic e_line, e_busy, e_done;
        int sz;
        sz = mq.size();
        e_line = brk ? 1'b0 : (lq.size() > 0 ? lq[0] : 1'b1);
        e_busy = brk || lq.size() > 0;
        e_done = !brk && lq.size() > 0 && dq[0];
        chk("uart_tx", 32'(uart_tx), 32'(e_line));
        chk("tx_busy", 32'(tx_busy), 32'(e_busy));
        chk("tx_done", 32'(tx_done), 32'(e_done));
        chk("tx_level", 32'(tx_level), 32'(sz));
        chk("tx_full", 32'(tx_full), 32'(sz == 16));
        chk("tx_ovf", 32'(tx_ovf), 32'(ovf_e));
        if (tx_done) got_done++;
        if (brk) begin
            if (!break_req) begin
                repeat (clamp_baud()) begin
                    lq.push_back(1'b1);
                    dq.push_back(1'b0);
                end
                brk = 1'b0;
            end
        end else if (lq.size() > 0) begin
            void'(lq.pop_front());
            void'(dq.pop_front());
        end else if (break_req) begin
            brk = 1'b1;
        end else if (sz > 0) begin
            build_frame(mq.pop_front());
        end
        ovf_e = tx_en && sz == 16;
        if (tx_en && sz < 16) mq.push_back(tx_data);
        @(negedge clk_sys);
    endtask

    task automatic wr(input logic [7:0] d);
        tx_en = 1'b1;
        tx_data = d;
        cyc();
        tx_en = 1'b0;
    endtask

    task automatic drain(input int max_c);
        int k = 0;
        while ((lq.size() > 0 || mq.size() > 0 || brk) && k < max_c) begin
            cyc();
            k++;
        end
        chk("drain_left", 32'(lq.size() + mq.size()), 32'd0);
        repeat (3) cyc();
    endtask

    initial begin
        @(negedge clk_sys);
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // basic 8N1 frame
        wr(8'hA5);
        drain(200);

        // parity odd, even, then two stop bits
        data_width = 4'd7; check_en = 1'b1; check_sel = 1'b1;
        wr(8'h41);
        drain(200);
        check_sel = 1'b0;
        wr(8'h41);
        drain(200);
        stop_bit = 1'b1;
        wr(8'h41);
        drain(200);

        // fill FIFO behind a break, overflow on the 17th write
        data_width = 4'd8; check_en = 1'b0; stop_bit = 1'b0;
        break_req = 1'b1;
        repeat (3) cyc();
        for (int i = 0; i < 17; i++) wr(8'($urandom));
        repeat (4) cyc();
        break_req = 1'b0;
        drain(2000);
        chk("frame_count", 32'(got_done), 32'(exp_done));

        // baud change mid-frame applies only to the next frame
        baud_rate = 16'd4;
        wr(8'($urandom));
        wr(8'($urandom));
        repeat (10) cyc();
        baud_rate = 16'd8;
        drain(500);

        // clamps: oversized width, tiny baud, undersized width
        data_width = 4'd12; baud_rate = 16'd1;
        wr(8'($urandom));
        drain(200);
        data_width = 4'd2; baud_rate = 16'd0;
        wr(8'($urandom));
        drain(200);

        // randomized traffic, config churn and short breaks
        for (int i = 0; i < 1500; i++) begin
            tx_en = $urandom_range(0, 5) == 0;
            tx_data = 8'($urandom);
            if ($urandom_range(0, 30) == 0) begin
                baud_rate = 16'($urandom_range(0, 5));
                data_width = 4'($urandom_range(0, 15));
                check_en = 1'($urandom);
                check_sel = 1'($urandom);
                stop_bit = 1'($urandom);
            end
            if ($urandom_range(0, 80) == 0) break_req = ~break_req;
            cyc();
        end
        tx_en = 1'b0;
        break_req = 1'b0;
        drain(5000);
        chk("frame_count_rand", 32'(got_done), 32'(exp_done));

        // reset in the middle of a frame with words queued
        baud_rate = 16'd4; data_width = 4'd8; check_en = 1'b0; stop_bit = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_level", 32'(tx_level), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        model_reset();
        @(negedge clk_sys);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (60) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
